// File: rtl/nrzi_deserializer_if.sv
// rtl/nrzi_deserializer_if.sv - line-bit input and recovered-word output bundle for nrzi_deserializer
//
// Signals:
//   in_valid  line bit present this cycle (never back-pressured)
//   in_bit    sampled line level
//   out_valid out_data holds an unconsumed word
//   out_ready consumer accepts the word on out_valid && out_ready
//   out_data  recovered word, bit 0 is the first bit received
//   overrun   sticky: a completed word was dropped
//   stuff_err sticky: bit-stuffing rule violated
// Modports:
//   master  line sampler + word consumer side
//   slave   the deserializer
interface nrzi_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             overrun;
    logic             stuff_err;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  overrun,
        input  stuff_err
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output out_valid,
        output out_data,
        output overrun,
        output stuff_err
    );
endinterface

// File: rtl/nrzi_deserializer.sv
// rtl/nrzi_deserializer.sv - NRZI line decoder and LSB-first word assembler
//
// Decodes one NRZI line bit per accepted cycle (unchanged level -> 1,
// transition -> 0), packs WIDTH decoded bits LSB-first and presents the word
// on a valid/ready output holding one word.
//
// Parameters:
//   WIDTH  recovered word width, 2..32
//   INIT   line level assumed before the first bit (only the LSB is kept)
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   bus    nrzi_deserializer_if.slave (in_valid/in_bit in, out_valid/
//          out_ready/out_data word handshake, sticky overrun/stuff_err)
// Build option:
//   NRZI_DESER_STUFF_EN  when defined, the bit after six consecutive decoded
//                        1s is discarded; a discarded 1 sets stuff_err.
module nrzi_deserializer #(
    parameter int         WIDTH = 8,
    parameter logic [0:0] INIT  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    nrzi_deserializer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

`ifdef NRZI_DESER_STUFF_EN
    typedef enum logic [0:0] {SHIFT, STUFF} state_t;
`else
    typedef enum logic [0:0] {SHIFT} state_t;
`endif

    state_t             state_q, state_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               overrun_q, overrun_d;
`ifdef NRZI_DESER_STUFF_EN
    logic [2:0]         ones_q, ones_d;
    logic               stuff_err_q, stuff_err_d;
`endif

    logic               dec;
    logic               keep;
    logic               complete;

    assign dec = ~(bus.in_bit ^ prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SHIFT;
            prev_q      <= INIT;
            cnt_q       <= '0;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
`ifdef NRZI_DESER_STUFF_EN
            ones_q      <= 3'd0;
            stuff_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
`ifdef NRZI_DESER_STUFF_EN
            ones_q      <= ones_d;
            stuff_err_q <= stuff_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;
`ifdef NRZI_DESER_STUFF_EN
        ones_d      = ones_q;
        stuff_err_d = stuff_err_q;
`endif
        keep        = 1'b0;
        complete    = 1'b0;

        if (bus.in_valid) begin
            // The line level is tracked for every accepted bit, including a
            // discarded stuff bit, so the decode after it stays correct.
            prev_d = bus.in_bit;
            case (state_q)
                SHIFT: begin
                    keep = 1'b1;
`ifdef NRZI_DESER_STUFF_EN
                    if (dec) begin
                        ones_d = ones_q + 3'd1;
                        // This is the sixth 1 in a row: the next bit is stuffing.
                        if (ones_q == 3'd5) begin
                            state_d = STUFF;
                        end
                    end else begin
                        ones_d = 3'd0;
                    end
`endif
                end
`ifdef NRZI_DESER_STUFF_EN
                STUFF: begin
                    ones_d  = 3'd0;
                    state_d = SHIFT;
                    if (dec) begin
                        stuff_err_d = 1'b1;
                    end
                end
`endif
                default: state_d = SHIFT;
            endcase
        end

        if (keep) begin
            sr_d[cnt_q] = dec;
            complete    = (cnt_q == CNT_W'(WIDTH - 1));
            cnt_d       = complete ? '0 : cnt_q + CNT_W'(1);
        end

        if (complete) begin
            // A same-cycle consume frees the holding register for the new word.
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = sr_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.overrun   = overrun_q;
`ifdef NRZI_DESER_STUFF_EN
    assign bus.stuff_err = stuff_err_q;
`else
    assign bus.stuff_err = 1'b0;
`endif
endmodule
